// File: rtl/vga_frame_reader.sv
// vga_frame_reader: display-side pixel fetch stage behind the 640x480@60Hz
// timing generator. Generates 2x-upscaled read addresses into a double-banked
// RGB565 frame buffer, re-aligns sync/DE with the RAM read latency, expands
// pixels to 8 bits per channel and shows colour bars until a first frame exists.
//
// Ports:
//   clk, reset_n          pixel clock, async active-low reset
//   h_count, v_count      scan position from the timing generator
//   hsync_in, vsync_in    negative-polarity syncs from the timing generator
//   video_on_in           visible-area flag
//   frame_ready           write path has a complete frame in the hidden bank
//   frame_ack             one-cycle pulse: bank swap taken
//   rd_bank               bank being displayed
//   rd_en, rd_addr        frame-buffer read request
//   rd_data               RGB565 read data, RD_LAT cycles after the request
//   vga_r/g/b             8-bit colour
//   vga_hs, vga_vs        delayed syncs (negative polarity)
//   vga_de                delayed data enable
module vga_frame_reader #(
  parameter int unsigned SRC_W  = 320,
  parameter int unsigned SRC_H  = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              video_on_in,
  input  logic              frame_ready,
  output logic              frame_ack,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de
);

  // Stages between the input sample and the output register (address reg + RAM).
  localparam int unsigned PIPE  = RD_LAT + 1;
  localparam int unsigned H_VIS = 2 * SRC_W;
  localparam int unsigned V_VIS = 2 * SRC_H;
  localparam int unsigned BAR_W = H_VIS / 8;

  logic [ADDR_W-1:0] line_base;
  logic              shown_valid;
  logic [PIPE-1:0]   hs_pipe;
  logic [PIPE-1:0]   vs_pipe;
  logic [PIPE-1:0]   de_pipe;
  logic [2:0]        bar_pipe [PIPE];

  logic       swap_evt_c;
  logic       line_adv_c;
  logic [2:0] bar_c;
  logic [7:0] r_c;
  logic [7:0] g_c;
  logic [7:0] b_c;

  // Start of vertical blanking is the only point where the bank may change.
  assign swap_evt_c = (h_count == 10'd0) && (v_count == 10'(V_VIS));
  // Advance one source line after every second visible output line.
  assign line_adv_c = (h_count == 10'(H_VIS - 1)) && (v_count < 10'(V_VIS)) && v_count[0];

  // Colour-bar index by threshold comparison, avoids a divider.
  always_comb begin
    bar_c = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_count >= 10'(BAR_W * i)) bar_c = 3'(i);
    end
  end

  // Output colour: image expansion, test pattern, or black in blanking.
  always_comb begin
    r_c = 8'h00;
    g_c = 8'h00;
    b_c = 8'h00;
    if (de_pipe[PIPE-1]) begin
      if (shown_valid) begin
        r_c = {rd_data[15:11], rd_data[15:13]};
        g_c = {rd_data[10:5],  rd_data[10:9]};
        b_c = {rd_data[4:0],   rd_data[4:2]};
      end else begin
        r_c = {8{bar_pipe[PIPE-1][2]}};
        g_c = {8{bar_pipe[PIPE-1][1]}};
        b_c = {8{bar_pipe[PIPE-1][0]}};
      end
    end
  end

  // Address generation, bank handshake and alignment pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr     <= '0;
      rd_en       <= 1'b0;
      rd_bank     <= 1'b0;
      frame_ack   <= 1'b0;
      line_base   <= '0;
      shown_valid <= 1'b0;
      hs_pipe     <= '1;
      vs_pipe     <= '1;
      de_pipe     <= '0;
      for (int i = 0; i < int'(PIPE); i++) bar_pipe[i] <= 3'd0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
    end else begin
      rd_en <= video_on_in;
      if (video_on_in) rd_addr <= line_base + ADDR_W'(h_count[9:1]);

      if (swap_evt_c)      line_base <= '0;
      else if (line_adv_c) line_base <= line_base + ADDR_W'(SRC_W);

      frame_ack <= swap_evt_c && frame_ready;
      if (swap_evt_c && frame_ready) begin
        rd_bank     <= ~rd_bank;
        shown_valid <= 1'b1;
      end

      hs_pipe     <= {hs_pipe[PIPE-2:0], hsync_in};
      vs_pipe     <= {vs_pipe[PIPE-2:0], vsync_in};
      de_pipe     <= {de_pipe[PIPE-2:0], video_on_in};
      bar_pipe[0] <= bar_c;
      for (int i = 1; i < int'(PIPE); i++) bar_pipe[i] <= bar_pipe[i-1];

      vga_hs <= hs_pipe[PIPE-1];
      vga_vs <= vs_pipe[PIPE-1];
      vga_de <= de_pipe[PIPE-1];
      vga_r  <= r_c;
      vga_g  <= g_c;
      vga_b  <= b_c;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader (RD_LAT=1). The scan position is driven
// per cycle and jumps between regions of interest to keep the run short.
module tb_vga_frame_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  h_count = 10'd700;
  logic [9:0]  v_count = 10'd500;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        video_on_in = 1'b0;
  logic        frame_ready = 1'b0;
  logic        frame_ack;
  logic        rd_bank;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic [15:0] rd_data = 16'h0000;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de;

  int checks = 0;
  int errors = 0;

  // RAM stand-in: returns its address unless a fixed value is forced.
  logic        ram_ovr = 1'b0;
  logic [15:0] ram_val = 16'h0000;

  // Inputs as sampled on the last three edges; index 2 is due at the outputs.
  logic hist_hs [3];
  logic hist_vs [3];
  logic hist_de [3];

  vga_frame_reader #(.SRC_W(320), .SRC_H(240), .ADDR_W(17), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .h_count(h_count), .v_count(v_count),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .rd_bank(rd_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= ram_ovr ? ram_val : rd_addr[15:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
    chk({tag, ".r"}, 32'(vga_r), 32'(r));
    chk({tag, ".g"}, 32'(vga_g), 32'(g));
    chk({tag, ".b"}, 32'(vga_b), 32'(b));
  endtask

  // Drive one scan position for one clock, then check the delayed syncs.
  task automatic apply(input int h, input int v);
    h_count     = 10'(h);
    v_count     = 10'(v);
    hsync_in    = !(h >= 656 && h < 752);
    vsync_in    = !(v >= 490 && v < 492);
    video_on_in = (h < 640) && (v < 480);
    @(posedge clk);
    #1;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        hist_hs[i] = 1'b1; hist_vs[i] = 1'b1; hist_de[i] = 1'b0;
      end
    end else begin
      hist_hs[2] = hist_hs[1]; hist_hs[1] = hist_hs[0]; hist_hs[0] = hsync_in;
      hist_vs[2] = hist_vs[1]; hist_vs[1] = hist_vs[0]; hist_vs[0] = vsync_in;
      hist_de[2] = hist_de[1]; hist_de[1] = hist_de[0]; hist_de[0] = video_on_in;
      chk("hs_delay", 32'(vga_hs), 32'(hist_hs[2]));
      chk("vs_delay", 32'(vga_vs), 32'(hist_vs[2]));
      chk("de_delay", 32'(vga_de), 32'(hist_de[2]));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, ".rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, ".rd_bank"}, 32'(rd_bank), 32'd0);
    chk({tag, ".ack"}, 32'(frame_ack), 32'd0);
    chk({tag, ".hs"}, 32'(vga_hs), 32'd1);
    chk({tag, ".vs"}, 32'(vga_vs), 32'd1);
    chk({tag, ".de"}, 32'(vga_de), 32'd0);
    chk_rgb({tag, ".rgb"}, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    int hp;
    logic [2:0] bar;
    for (int i = 0; i < 3; i++) begin
      hist_hs[i] = 1'b1; hist_vs[i] = 1'b1; hist_de[i] = 1'b0;
    end

    // Reset state
    for (int i = 0; i < 3; i++) apply(700, 500);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // Frame 0: no image yet, colour bars on line 10
    for (int v = 0; v < 480; v++) begin
      if (v == 10) begin
        for (int h = 0; h < 646; h++) begin
          apply(h, v);
          hp = h - 2;
          if (hp >= 640) begin
            chk_rgb("blank", 8'h00, 8'h00, 8'h00);
          end else if (hp >= 0 && ((hp % 80) == 0 || (hp % 80) == 79)) begin
            bar = 3'(hp / 80);
            chk_rgb($sformatf("bar%0d_h%0d", bar, hp),
                    bar[2] ? 8'hFF : 8'h00, bar[1] ? 8'hFF : 8'h00, bar[0] ? 8'hFF : 8'h00);
          end
        end
      end else begin
        apply(639, v);
      end
    end

    // First swap: frame_ready held at blanking start
    frame_ready = 1'b1;
    apply(0, 480);
    chk("swap1.ack", 32'(frame_ack), 32'd1);
    chk("swap1.bank", 32'(rd_bank), 32'd1);
    apply(1, 480);
    chk("swap1.ack_pulse", 32'(frame_ack), 32'd0);
    frame_ready = 1'b0;
    for (int h = 650; h < 760; h++) apply(h, 480);
    for (int h = 795; h < 800; h++) apply(h, 489);
    for (int h = 0; h < 6; h++) apply(h, 490);
    for (int h = 0; h < 4; h++) apply(h, 492);

    // Frame 1: image mode, addressing and RGB565 expansion
    for (int v = 0; v < 480; v++) begin
      if (v == 0) begin
        apply(0, 0); chk("addr_h0v0", 32'(rd_addr), 32'd0);
        apply(1, 0); chk("addr_h1v0", 32'(rd_addr), 32'd0);
        apply(2, 0); chk("addr_h2v0", 32'(rd_addr), 32'd1);
      end else if (v == 1) begin
        apply(0, 1); chk("addr_h0v1", 32'(rd_addr), 32'd0);
        apply(1, 1); chk("addr_h1v1", 32'(rd_addr), 32'd0);
      end else if (v == 2) begin
        apply(0, 2); chk("addr_h0v2", 32'(rd_addr), 32'd320);
      end else if (v == 3) begin
        apply(5, 3); chk("addr_h5v3", 32'(rd_addr), 32'd322);
      end else if (v == 4) begin
        ram_ovr = 1'b1;
        ram_val = 16'hF800;
        apply(100, 4); apply(101, 4); apply(102, 4);
        chk_rgb("img_F800", 8'hFF, 8'h00, 8'h00);
        ram_val = 16'h07E0;
        apply(103, 4); apply(104, 4); apply(105, 4);
        chk_rgb("img_07E0", 8'h00, 8'hFF, 8'h00);
        ram_val = 16'h0821;
        apply(106, 4); apply(107, 4); apply(108, 4);
        chk_rgb("img_0821", 8'h08, 8'h04, 8'h08);
        ram_ovr = 1'b0;
      end else if (v == 6) begin
        apply(200, 6); apply(201, 6); apply(202, 6);
        chk("addr_h200v6", 32'(rd_addr), 32'd1061);
        chk_rgb("img_addr1060", 8'h00, 8'h86, 8'h21);
      end else if (v == 479) begin
        apply(638, 479);
      end
      apply(639, v);
      if (v == 479) chk("addr_h639v479", 32'(rd_addr), 32'd76799);
    end

    // No frame ready: no swap, same bank
    apply(0, 480);
    chk("noswap.ack", 32'(frame_ack), 32'd0);
    chk("noswap.bank", 32'(rd_bank), 32'd1);
    apply(1, 480);
    chk("noswap.ack2", 32'(frame_ack), 32'd0);

    // Reset mid-frame while an ack is pending
    for (int h = 290; h < 300; h++) apply(h, 200);
    frame_ready = 1'b1;
    apply(0, 480);
    chk("pend.ack", 32'(frame_ack), 32'd1);
    h_count = 10'd300;
    v_count = 10'd200;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_now");
    frame_ready = 1'b0;
    for (int h = 300; h < 305; h++) apply(h, 200);
    chk_reset_outputs("rst_hold");
    reset_n = 1'b1;
    for (int h = 305; h < 310; h++) apply(h, 200);
    apply(639, 200);
    apply(85, 201); apply(86, 201); apply(87, 201);
    chk_rgb("post_rst_bar1", 8'h00, 8'h00, 8'hFF);

    // Swap after reset, image on the following frame
    frame_ready = 1'b1;
    apply(0, 480);
    chk("swap2.ack", 32'(frame_ack), 32'd1);
    chk("swap2.bank", 32'(rd_bank), 32'd1);
    frame_ready = 1'b0;
    apply(1, 480);
    chk("swap2.ack_pulse", 32'(frame_ack), 32'd0);
    apply(2, 0); apply(3, 0); apply(4, 0);
    chk_rgb("swap2.img_addr1", 8'h00, 8'h00, 8'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
